// File: rtl/matrix_mac_engine.sv
// Square signed matrix multiplier C = A*B that reads A/B through a 1-cycle-latency read port.
// Optional output clamping is enabled by defining MATRIX_MAC_SATURATE_EN (default: wrap).
module matrix_mac_engine #(
    parameter int MAX_WIDTH_LEN = 3,
    parameter int SIZE_VALUE    = 16,
    parameter int ACC_WIDTH     = 2*SIZE_VALUE+MAX_WIDTH_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [MAX_WIDTH_LEN-1:0]     dim_m1,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [MAX_WIDTH_LEN-1:0]     rd_x1,
    output logic [MAX_WIDTH_LEN-1:0]     rd_y1,
    output logic [MAX_WIDTH_LEN-1:0]     rd_x2,
    output logic [MAX_WIDTH_LEN-1:0]     rd_y2,
    input  logic signed [SIZE_VALUE-1:0] rd_data1,
    input  logic signed [SIZE_VALUE-1:0] rd_data2,
    output logic                         wr_en,
    output logic [MAX_WIDTH_LEN-1:0]     wr_x,
    output logic [MAX_WIDTH_LEN-1:0]     wr_y,
    output logic signed [SIZE_VALUE-1:0] wr_data
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t                       state_q, state_d;
    logic [MAX_WIDTH_LEN-1:0]     dim_q, dim_d;
    logic [MAX_WIDTH_LEN-1:0]     i_q, i_d;
    logic [MAX_WIDTH_LEN-1:0]     j_q, j_d;
    logic [MAX_WIDTH_LEN-1:0]     k_q, k_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         valid_q, valid_d;

    logic signed [2*SIZE_VALUE-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [SIZE_VALUE-1:0]   result;

    assign prod     = rd_data1 * rd_data2;
    assign prod_ext = ACC_WIDTH'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dim_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dim_q   <= dim_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (k_q == dim_q) state_d = DRAIN;
            DRAIN:   state_d = WRITE;
            WRITE:   state_d = ((j_q < dim_q) || (i_q < dim_q)) ? READ : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data trails rd_en by one cycle, so accumulation is keyed off valid_q, not the state.
    always_comb begin
        dim_d   = dim_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = valid_q ? (acc_q + prod_ext) : acc_q;
        valid_d = rd_en;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dim_d = dim_m1;
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                end
            end
            READ: begin
                if (k_q != dim_q) k_d = k_q + 1'b1;
            end
            WRITE: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q < dim_q) begin
                    j_d = j_q + 1'b1;
                end else if (i_q < dim_q) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef MATRIX_MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-SIZE_VALUE+1){1'b0}}, {(SIZE_VALUE-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-SIZE_VALUE+1){1'b1}}, {(SIZE_VALUE-1){1'b0}}};

    always_comb begin
        if (acc_q > SAT_MAX)      result = SAT_MAX[SIZE_VALUE-1:0];
        else if (acc_q < SAT_MIN) result = SAT_MIN[SIZE_VALUE-1:0];
        else                      result = acc_q[SIZE_VALUE-1:0];
    end
`else
    always_comb begin
        result = acc_q[SIZE_VALUE-1:0];
    end
`endif

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_x1   = '0;
        rd_y1   = '0;
        rd_x2   = '0;
        rd_y2   = '0;
        wr_en   = 1'b0;
        wr_x    = '0;
        wr_y    = '0;
        wr_data = '0;
        case (state_q)
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                rd_x1 = k_q;
                rd_y1 = i_q;
                rd_x2 = j_q;
                rd_y2 = k_q;
            end
            DRAIN: busy = 1'b1;
            WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_x    = j_q;
                wr_y    = i_q;
                wr_data = result;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Self-checking bench for matrix_mac_engine: memory-backed read port plus a cycle-indexed reference model.
// Honours MATRIX_MAC_SATURATE_EN in the model's result conversion.
module tb_matrix_mac_engine;

    localparam int MW = 3;
    localparam int SV = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [MW-1:0]        dimM1 = '0;
    logic                 busy, done, rdEn, wrEn;
    logic [MW-1:0]        rdX1, rdY1, rdX2, rdY2, wrX, wrY;
    logic signed [SV-1:0] rdData1 = '0;
    logic signed [SV-1:0] rdData2 = '0;
    logic signed [SV-1:0] wrData;

    logic signed [SV-1:0] memA [8][8];
    logic signed [SV-1:0] memB [8][8];
    logic [SV-1:0]        expC [8][8];

    int errors = 0;
    int checks = 0;

    matrix_mac_engine #(.MAX_WIDTH_LEN(MW), .SIZE_VALUE(SV)) dut (
        .clk(clk), .rst(rst), .start(start), .dim_m1(dimM1),
        .busy(busy), .done(done), .rd_en(rdEn),
        .rd_x1(rdX1), .rd_y1(rdY1), .rd_x2(rdX2), .rd_y2(rdY2),
        .rd_data1(rdData1), .rd_data2(rdData2),
        .wr_en(wrEn), .wr_x(wrX), .wr_y(wrY), .wr_data(wrData)
    );

    always #5 clk = ~clk;

    // Connector model: returns the selected elements one cycle later, zero when not selected.
    always @(posedge clk) begin
        rdData1 <= rdEn ? memA[rdY1][rdX1] : '0;
        rdData2 <= rdEn ? memB[rdY2][rdX2] : '0;
    end

    function automatic logic [SV-1:0] toResult(input longint s);
        longint hi = (64'sd1 <<< (SV-1)) - 1;
        longint lo = -(64'sd1 <<< (SV-1));
        logic [63:0] raw;
`ifdef MATRIX_MAC_SATURATE_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`endif
        raw = s;
        return raw[SV-1:0];
    endfunction

    function automatic void computeExpected(input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                longint sum = 0;
                for (int k = 0; k < n; k++)
                    sum += longint'(memA[i][k]) * longint'(memB[k][j]);
                expC[i][j] = toResult(sum);
            end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ctl"}, {28'd0, busy, done, rdEn, wrEn}, 32'd0);
        checkOutput({tag, "_idx"}, {8'd0, rdX1, rdY1, rdX2, rdY2, wrX, wrY}, 32'd0);
        checkOutput({tag, "_wdata"}, {16'd0, wrData}, 32'd0);
    endtask

    // Expected behaviour for cycle c counted from the cycle where start was sampled (c=0).
    task automatic checkCycle(input int c, input int n);
        int perElem = n + 2;
        int last    = n * n * perElem;
        int phase   = (c - 1) % perElem;
        int elem    = (c - 1) / perElem;
        bit inRun   = (c <= last);
        bit expRd   = inRun && (phase < n);
        bit expWr   = inRun && (phase == n + 1);
        int ei      = elem / n;
        int ej      = elem % n;
        logic [2:0] k3, i3, j3;
        k3 = 3'(phase);
        i3 = 3'(ei);
        j3 = 3'(ej);
        checkOutput($sformatf("busy@%0d", c), {31'd0, busy}, {31'd0, inRun});
        checkOutput($sformatf("done@%0d", c), {31'd0, done}, {31'd0, (c == last + 1)});
        checkOutput($sformatf("rd_en@%0d", c), {31'd0, rdEn}, {31'd0, expRd});
        checkOutput($sformatf("wr_en@%0d", c), {31'd0, wrEn}, {31'd0, expWr});
        if (expRd)
            checkOutput($sformatf("rd_idx@%0d", c), {20'd0, rdX1, rdY1, rdX2, rdY2},
                        {20'd0, k3, i3, j3, k3});
        else
            checkOutput($sformatf("rd_idx0@%0d", c), {20'd0, rdX1, rdY1, rdX2, rdY2}, 32'd0);
        if (expWr) begin
            checkOutput($sformatf("wr_xy@%0d", c), {26'd0, wrY, wrX}, {26'd0, i3, j3});
            checkOutput($sformatf("wr_data@%0d", c), {16'd0, wrData}, {16'd0, expC[ei][ej]});
        end else begin
            checkOutput($sformatf("wr_zero@%0d", c), {10'd0, wrY, wrX, wrData}, 32'd0);
        end
    endtask

    // Runs one multiply of size n; restartAt pulses start mid-run, abortAt asserts reset mid-run.
    task automatic applyStimulus(input int n, input int restartAt, input int abortAt);
        int last = n * n * (n + 2);
        computeExpected(n);
        @(negedge clk);
        dimM1 = 3'(n - 1);
        start = 1'b1;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                dimM1 = 3'($urandom);
            end
            if (restartAt != 0) start = (c == restartAt);
            if (abortAt != 0 && c == abortAt) begin
                rst = 1'b1;
                #1;
                checkIdleOutputs("abort_now");
                for (int w = 0; w < 3; w++) begin
                    @(negedge clk);
                    checkIdleOutputs($sformatf("abort_hold%0d", w));
                end
                rst = 1'b0;
                @(negedge clk);
                checkIdleOutputs("abort_after");
                return;
            end
            checkCycle(c, n);
        end
    endtask

    task automatic fillConst(input int n, input int a, input int b);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                memA[i][j] = (i < n && j < n) ? SV'(a) : '0;
                memB[i][j] = (i < n && j < n) ? SV'(b) : '0;
            end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                memA[i][j] = SV'($urandom);
                memB[i][j] = SV'($urandom);
            end
    endtask

    initial begin
        fillConst(8, 0, 0);
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("post_reset");

        $display("[TB] identity x [[1,2],[3,4]]");
        fillConst(2, 0, 0);
        memA[0][0] = 16'sd1; memA[1][1] = 16'sd1;
        memB[0][0] = 16'sd1; memB[0][1] = 16'sd2;
        memB[1][0] = 16'sd3; memB[1][1] = 16'sd4;
        applyStimulus(2, 0, 0);

        $display("[TB] 1x1 negative product");
        fillConst(1, -3, 5);
        applyStimulus(1, 0, 0);

        $display("[TB] 1x1 overflow, positive and negative");
        fillConst(1, 300, 300);
        applyStimulus(1, 0, 0);
        fillConst(1, -300, 300);
        applyStimulus(1, 0, 0);

        $display("[TB] 3x3 all twos with ignored restart");
        fillConst(3, 2, 2);
        applyStimulus(3, 7, 0);

        $display("[TB] 2x2 reset mid-run then full rerun");
        fillRandom();
        applyStimulus(2, 0, 6);
        applyStimulus(2, 0, 0);

        $display("[TB] random 4x4 and 8x8");
        fillRandom();
        applyStimulus(4, 0, 0);
        fillRandom();
        applyStimulus(8, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
